// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//
// Purpose:
//   Shares one valid/ready beat stream between NUM_REQ upstream requesters.
//   Arbitration is round-robin and packet-granular. Once a requester is
//   granted, it owns the downstream channel until its last beat is accepted.
//   There is always one idle cycle between packets. Within a packet the
//   throughput is one beat per cycle.
//
// Handshake:
//   A beat moves on any rising clk edge where valid and ready are both high.
//   A source never waits for ready before raising valid. The only path from
//   out_ready goes to the ready of the granted requester. No path leads from
//   out_ready back into a valid.
//
// Ports:
//   clk        system clock; all logic uses the rising edge
//   rst_n      asynchronous active-low reset, released synchronously
//   req_valid  per-requester beat valid                    [NUM_REQ]
//   req_data   per-requester payload, requester i at
//              [i*DATA_WIDTH +: DATA_WIDTH]                [NUM_REQ*DATA_WIDTH]
//   req_last   per-requester last-beat flag                [NUM_REQ]
//   req_ready  per-requester ready (only the granted one)  [NUM_REQ]
//   out_valid  downstream beat valid
//   out_data   downstream payload                          [DATA_WIDTH]
//   out_last   downstream last-beat flag
//   out_ready  downstream ready
//   grant_id   current grant, or the last grant while idle [$clog2(NUM_REQ)]
//   busy       high while a grant is held (FSM state LOCK); doubles as the
//              FSM state observation point
//   pkt_count  packets completed since reset, wrapping     [CNT_WIDTH]
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pkt_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    // Unpack the flat payload bus so the granted lane can be selected by index.
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Signals of the currently granted lane
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign sel_data  = req_data_arr[grant_q];

    // A packet completes when its last beat is accepted while the grant is held.
    logic pkt_done;

    assign pkt_done = (state_q == ST_LOCK) && sel_valid && out_ready && sel_last;

    // Round-robin pointer after the current grant, wrapping at NUM_REQ.
    // NUM_REQ may not be a power of two, so the wrap is explicit.
    logic [IDW-1:0] ptr_after_grant;

    assign ptr_after_grant = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // -------------------------------------------------------------------------
    // Round-robin pick
    // The scan runs from the farthest offset down to offset 0. The last hit
    // then belongs to the requester nearest rr_ptr, which gives the first
    // valid index at or after the pointer.
    // -------------------------------------------------------------------------
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    int unsigned    scan_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req_valid[IDW'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'(scan_idx);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // The grant is registered. Data can move one cycle after the
                // request first becomes visible, at the earliest.
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // Valid may drop mid-packet. The grant is still held until
                // the last beat is accepted.
                if (pkt_done) begin
                    rr_ptr_d  = ptr_after_grant;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // The mux is combinational. While in LOCK, out_* follow the granted lane
    // within the same cycle. While in IDLE (and therefore under reset), every
    // stream output is forced to zero.
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        busy      = 1'b0;
        case (state_q)
            ST_LOCK: begin
                busy               = 1'b1;
                out_valid          = sel_valid;
                out_data           = sel_data;
                out_last           = sel_last;
                req_ready[grant_q] = out_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign grant_id  = grant_q;
    assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Directed bench for stream_rr_arbiter. Each requester replays a table of
// beats loaded by load_pkt. Every beat loaded is also pushed, tagged with its
// requester index, onto exp_q in the order the arbiter is expected to serve
// it. Each downstream transfer pops exp_q and compares the entry.
// pkt_count is compared every cycle against a wrapping model counter.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int IDW = 2;
    localparam int SW  = IDW + 1 + DW;
    localparam int CAP = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic             out_ready;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic [CW-1:0]    pkt_count;

    stream_rr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    // ---------------- sources, scoreboard, counters ----------------
    logic [DW-1:0] src_data [NR][CAP];
    logic          src_last [NR][CAP];
    int            src_len  [NR];
    int            src_pos  [NR];
    logic          src_hold [NR];

    logic [SW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt;
    logic          prev_last_fire;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            src_len[i]  = 0;
            src_pos[i]  = 0;
            src_hold[i] = 1'b0;
        end
        exp_cnt        = '0;
        prev_last_fire = 1'b0;
    endtask

    function automatic bit src_pending();
        for (int i = 0; i < NR; i++) begin
            if (src_pos[i] < src_len[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Appends one packet to a requester's table and records its expected beats
    task automatic load_pkt(input int id, input int nbeats);
        logic [DW-1:0] d;
        logic          lst;
        for (int b = 0; b < nbeats; b++) begin
            d   = $urandom_range(32'hFFFF_FFFF, 0);
            lst = (b == nbeats - 1);
            src_data[id][src_len[id]] = d;
            src_last[id][src_len[id]] = lst;
            src_len[id]++;
            exp_q.push_back({IDW'(id), lst, d});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i]          = !src_hold[i];
                req_data[i*DW +: DW]  = src_data[i][src_pos[i]];
                req_last[i]           = src_last[i][src_pos[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    // One clock cycle. Outputs are sampled at the falling edge. Inputs are
    // advanced and re-driven just after the rising edge.
    task automatic step();
        logic [NR-1:0] fire;
        logic          last_fire;
        logic [SW-1:0] e;
        @(negedge clk);
        if (prev_last_fire) begin
            chk("idle_gap_busy", 64'(busy), 64'd0);
        end
        chk("pkt_count", 64'(pkt_count), 64'(exp_cnt));
        fire      = req_valid & req_ready;
        last_fire = out_valid & out_ready & out_last;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_grant_last_data", 64'({grant_id, out_last, out_data}), 64'(e));
            end
        end
        if (last_fire) exp_cnt = exp_cnt + 1'b1;
        prev_last_fire = last_fire;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (fire[i]) src_pos[i]++;
        end
        drive();
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        clear_model();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- directed sequence ----------------
    int ready_pat [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    int hold_pat  [8] = '{0, 0, 0, 0, 1, 1, 0, 0};

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        clear_model();
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_grant_id",  64'(grant_id),  64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Single requester 2, three beats
        out_ready = 1'b1;
        load_pkt(2, 3);
        drive();
        #1;
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_ready", 64'(req_ready), 64'd0);
        step();
        chk("t1_grant_id", 64'(grant_id), 64'd2);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_req_ready", 64'(req_ready), 64'b0100);
        wait_drain(20);
        step();
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);
        chk("t1_back_idle", 64'(busy), 64'd0);

        // All four requesters valid together, two-beat packets; requester 0 comes back
        do_reset();
        out_ready = 1'b1;
        load_pkt(0, 2);
        load_pkt(1, 2);
        load_pkt(2, 2);
        load_pkt(3, 2);
        load_pkt(0, 2);
        drive();
        wait_drain(60);
        step();
        chk("t2_pkt_count", 64'(pkt_count), 64'd5);

        // Backpressure plus a valid gap on requester 1 while requester 3 waits
        out_ready = 1'b1;
        load_pkt(1, 4);
        drive();
        step();
        chk("t3_grant_id", 64'(grant_id), 64'd1);
        load_pkt(3, 2);
        drive();
        for (int k = 0; k < 8; k++) begin
            out_ready   = ready_pat[k][0];
            src_hold[1] = hold_pat[k][0];
            drive();
            #1;
            chk("t3_hold_grant", 64'(grant_id), 64'd1);
            chk("t3_busy", 64'(busy), 64'd1);
            chk("t3_ready3_low", 64'(req_ready[3]), 64'd0);
            chk("t3_ready1_follows", 64'(req_ready[1]), 64'(out_ready));
            step();
        end
        out_ready = 1'b1;
        wait_drain(20);

        // Pointer wrap: requester 3 just finished, 0 and 2 request together
        load_pkt(0, 2);
        load_pkt(2, 2);
        drive();
        step();
        chk("t4_first_grant", 64'(grant_id), 64'd0);
        wait_drain(20);

        // Reset during beat 2 of requester 2's four-beat packet
        load_pkt(2, 4);
        drive();
        step();
        chk("t5_grant_id", 64'(grant_id), 64'd2);
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_out_data",  64'(out_data),  64'd0);
        chk("t5_rst_out_last",  64'(out_last),  64'd0);
        chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
        chk("t5_rst_busy",      64'(busy),      64'd0);
        chk("t5_rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("t5_rst_grant_id",  64'(grant_id),  64'd0);
        clear_model();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        load_pkt(1, 2);
        load_pkt(2, 2);
        drive();
        step();
        chk("t5_post_rst_grant", 64'(grant_id), 64'd1);
        wait_drain(20);

        // Counter wrap with a 4-bit counter: 17 single-beat packets
        do_reset();
        out_ready = 1'b1;
        for (int p = 0; p < 17; p++) begin
            load_pkt(0, 1);
        end
        drive();
        wait_drain(100);
        step();
        chk("t6_pkt_count_wrap", 64'(pkt_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
